// File: rtl/store_write_buffer_pkg.sv
// Shared encodings for the store write buffer.
// Store sizes, FSM states and the aligned-lane bundle.
package store_write_buffer_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] wd;
        logic [3:0]  be;
    } lane_t;

endpackage

// File: rtl/store_align.sv
// Byte-lane alignment of store data and byte-enable generation.
// Purely combinational; flags misaligned or reserved-size stores.
module store_align
    import store_write_buffer_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wd_i,
    output logic [31:0] wd_o,
    output logic [3:0]  be_o,
    output logic        misaligned_o
);

    lane_t lane;

    always_comb begin
        lane         = '0;
        misaligned_o = 1'b0;
        unique case (size_i)
            SZ_WORD: begin
                lane.wd      = wd_i;
                lane.be      = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            SZ_HALF: begin
                lane.wd      = {2{wd_i[15:0]}};
                lane.be      = 4'b0011 << addr_lo_i;
                misaligned_o = addr_lo_i[0];
            end
            SZ_BYTE: begin
                lane.wd = {4{wd_i[7:0]}};
                lane.be = 4'b0001 << addr_lo_i;
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

    assign wd_o = lane.wd;
    assign be_o = lane.be;

endmodule

// File: rtl/store_write_buffer.sv
// Store queue between the MEM stage and data memory.
// Aligns stores, buffers them in a FIFO and drains via MREQ/MACK.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
)
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          WE,
    input  logic [1:0]    SIZE,
    input  logic [AW-1:0] ADDR,
    input  logic [31:0]   WD,
    output logic          STALL,
    output logic          ERR,
    output logic          FULL,
    output logic          EMPTY,
    output logic          MREQ,
    output logic [AW-1:0] MADDR,
    output logic [31:0]   MWD,
    output logic [3:0]    MBE,
    input  logic          MACK
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [31:0]   al_wd;
    logic [3:0]    al_be;
    logic          al_mis;

    state_e        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, err_q;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [31:0]   mwd_q, mwd_d;
    logic [3:0]    mbe_q, mbe_d;

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [31:0]   wd_mem_q   [DEPTH];
    logic [3:0]    be_mem_q   [DEPTH];

    logic          enq, pop, load_head, bypass;
    logic [PW-1:0] head_idx;
    logic [AW-1:0] enq_addr;

    store_align u_align (
        .size_i       (SIZE),
        .addr_lo_i    (ADDR[1:0]),
        .wd_i         (WD),
        .wd_o         (al_wd),
        .be_o         (al_be),
        .misaligned_o (al_mis)
    );

    assign enq      = WE & ~full_q & ~al_mis;
    assign pop      = (state_q == REQ) & MACK;
    assign enq_addr = {ADDR[AW-1:2], 2'b00};

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) wptr_d = wptr_q + 1'b1;
        if (pop) rptr_d = rptr_q + 1'b1;
        unique case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        head_idx  = rptr_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d   = REQ;
                    load_head = 1'b1;
                end
            end
            REQ: begin
                if (MACK) begin
                    head_idx = rptr_q + 1'b1;
                    if (count_d != '0) load_head = 1'b1;
                    else               state_d   = IDLE;
                end
            end
        endcase
    end

    // A store entering on the pop edge may become the new head at once.
    assign bypass = enq & (wptr_q == head_idx);

    always_comb begin
        maddr_d = maddr_q;
        mwd_d   = mwd_q;
        mbe_d   = mbe_q;
        if (load_head) begin
            if (bypass) begin
                maddr_d = enq_addr;
                mwd_d   = al_wd;
                mbe_d   = al_be;
            end else begin
                maddr_d = addr_mem_q[head_idx];
                mwd_d   = wd_mem_q[head_idx];
                mbe_d   = be_mem_q[head_idx];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
            maddr_q <= '0;
            mwd_q   <= '0;
            mbe_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
            err_q   <= WE & ~full_q & al_mis;
            maddr_q <= maddr_d;
            mwd_q   <= mwd_d;
            mbe_q   <= mbe_d;
        end
    end

    // Entry storage needs no reset: count and pointers define validity.
    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_mem_q[wptr_q] <= enq_addr;
            wd_mem_q[wptr_q]   <= al_wd;
            be_mem_q[wptr_q]   <= al_be;
        end
    end

    assign STALL = WE & full_q;
    assign ERR   = err_q;
    assign FULL  = full_q;
    assign EMPTY = empty_q;
    assign MREQ  = (state_q == REQ);
    assign MADDR = maddr_q;
    assign MWD   = mwd_q;
    assign MBE   = mbe_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer (DEPTH = 2).
// Drives 1ns after the rising edge and samples there too.
module tb_store_write_buffer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WE;
    logic [1:0]  SIZE;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic        STALL, ERR, FULL, EMPTY, MREQ;
    logic [31:0] MADDR, MWD;
    logic [3:0]  MBE;
    logic        MACK;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ack_log [$];

    store_write_buffer #(.DEPTH(2), .AW(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .WE    (WE),
        .SIZE  (SIZE),
        .ADDR  (ADDR),
        .WD    (WD),
        .STALL (STALL),
        .ERR   (ERR),
        .FULL  (FULL),
        .EMPTY (EMPTY),
        .MREQ  (MREQ),
        .MADDR (MADDR),
        .MWD   (MWD),
        .MBE   (MBE),
        .MACK  (MACK)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RST_N && MREQ && MACK) ack_log.push_back(MADDR);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        WE   = we;
        SIZE = sz;
        ADDR = a;
        WD   = d;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        MACK  = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick;
        tick;
        n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL rst_mreq got=%b exp=0", MREQ); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", EMPTY); end
        n_cmp++; if (FULL !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", FULL); end
        n_cmp++; if (ERR !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", ERR); end
        n_cmp++; if ({MADDR, MWD, MBE} !== 68'h0) begin n_err++; $display("FAIL rst_outs got=%h/%h/%b exp=0", MADDR, MWD, MBE); end
        RST_N = 1'b1;
        tick;
    endtask

    task automatic test_sw;
        drive(1'b1, 2'b10, 32'h0000_0104, 32'hDEAD_BEEF);
        tick;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL sw_mreq_early got=%b exp=0", MREQ); end
        n_cmp++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL sw_empty_q got=%b exp=0", EMPTY); end
        tick;
        n_cmp++; if (MREQ !== 1'b1) begin n_err++; $display("FAIL sw_mreq got=%b exp=1", MREQ); end
        n_cmp++; if (MADDR !== 32'h0000_0104) begin n_err++; $display("FAIL sw_maddr got=%h exp=00000104", MADDR); end
        n_cmp++; if (MWD !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sw_mwd got=%h exp=deadbeef", MWD); end
        n_cmp++; if (MBE !== 4'b1111) begin n_err++; $display("FAIL sw_mbe got=%b exp=1111", MBE); end
        MACK = 1'b1;
        tick;
        MACK = 1'b0;
        n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL sw_idle got=%b exp=0", MREQ); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL sw_empty got=%b exp=1", EMPTY); end
        n_cmp++; if (MADDR !== 32'h0000_0104) begin n_err++; $display("FAIL sw_hold got=%h exp=00000104", MADDR); end
    endtask

    task automatic test_sb;
        drive(1'b1, 2'b00, 32'h0000_0013, 32'h0000_00A5);
        tick;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick;
        n_cmp++; if (MREQ !== 1'b1) begin n_err++; $display("FAIL sb_mreq got=%b exp=1", MREQ); end
        n_cmp++; if (MADDR !== 32'h0000_0010) begin n_err++; $display("FAIL sb_maddr got=%h exp=00000010", MADDR); end
        n_cmp++; if (MWD !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL sb_mwd got=%h exp=a5a5a5a5", MWD); end
        n_cmp++; if (MBE !== 4'b1000) begin n_err++; $display("FAIL sb_mbe got=%b exp=1000", MBE); end
        MACK = 1'b1;
        tick;
        MACK = 1'b0;
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL sb_empty got=%b exp=1", EMPTY); end
    endtask

    task automatic test_sh;
        drive(1'b1, 2'b01, 32'h0000_0022, 32'h0000_1234);
        tick;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick;
        n_cmp++; if (MADDR !== 32'h0000_0020) begin n_err++; $display("FAIL sh_maddr got=%h exp=00000020", MADDR); end
        n_cmp++; if (MWD !== 32'h1234_1234) begin n_err++; $display("FAIL sh_mwd got=%h exp=12341234", MWD); end
        n_cmp++; if (MBE !== 4'b1100) begin n_err++; $display("FAIL sh_mbe got=%b exp=1100", MBE); end
        MACK = 1'b1;
        tick;
        MACK = 1'b0;
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL sh_empty got=%b exp=1", EMPTY); end
    endtask

    task automatic test_misaligned;
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 2'b01; ad[0] = 32'h0000_0021;
        sz[1] = 2'b10; ad[1] = 32'h0000_0102;
        sz[2] = 2'b11; ad[2] = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sz[i], ad[i], 32'h5555_AAAA);
            n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL mis%0d_stall got=%b exp=0", i, STALL); end
            tick;
            drive(1'b0, 2'b00, 32'h0, 32'h0);
            n_cmp++; if (ERR !== 1'b1) begin n_err++; $display("FAIL mis%0d_err got=%b exp=1", i, ERR); end
            n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL mis%0d_empty got=%b exp=1", i, EMPTY); end
            tick;
            n_cmp++; if (ERR !== 1'b0) begin n_err++; $display("FAIL mis%0d_err_pulse got=%b exp=0", i, ERR); end
            n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL mis%0d_mreq got=%b exp=0", i, MREQ); end
        end
    endtask

    task automatic test_back_to_back;
        ack_log.delete();
        MACK = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_0200, 32'hA000_0001);
        tick;
        drive(1'b1, 2'b10, 32'h0000_0204, 32'hB000_0002);
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL b2b_stall_b got=%b exp=0", STALL); end
        tick;
        drive(1'b1, 2'b10, 32'h0000_0208, 32'hC000_0003);
        n_cmp++; if (FULL !== 1'b1) begin n_err++; $display("FAIL b2b_full got=%b exp=1", FULL); end
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL b2b_stall_c got=%b exp=1", STALL); end
        n_cmp++; if (MADDR !== 32'h0000_0200) begin n_err++; $display("FAIL b2b_head_a got=%h exp=00000200", MADDR); end
        tick;
        n_cmp++; if (STALL !== 1'b1) begin n_err++; $display("FAIL b2b_stall_hold got=%b exp=1", STALL); end
        n_cmp++; if (MWD !== 32'hA000_0001) begin n_err++; $display("FAIL b2b_mwd_a got=%h exp=a0000001", MWD); end
        MACK = 1'b1;
        tick;
        n_cmp++; if (MADDR !== 32'h0000_0204) begin n_err++; $display("FAIL b2b_head_b got=%h exp=00000204", MADDR); end
        n_cmp++; if (MREQ !== 1'b1) begin n_err++; $display("FAIL b2b_mreq_b got=%b exp=1", MREQ); end
        n_cmp++; if (STALL !== 1'b0) begin n_err++; $display("FAIL b2b_unstall got=%b exp=0", STALL); end
        tick;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        n_cmp++; if (MADDR !== 32'h0000_0208) begin n_err++; $display("FAIL b2b_head_c got=%h exp=00000208", MADDR); end
        n_cmp++; if (MWD !== 32'hC000_0003) begin n_err++; $display("FAIL b2b_mwd_c got=%h exp=c0000003", MWD); end
        n_cmp++; if (EMPTY !== 1'b0) begin n_err++; $display("FAIL b2b_notempty got=%b exp=0", EMPTY); end
        tick;
        MACK = 1'b0;
        n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", MREQ); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", EMPTY); end
        n_cmp++; if (ack_log.size() !== 3) begin n_err++; $display("FAIL b2b_acks got=%0d exp=3", ack_log.size()); end
        if (ack_log.size() == 3) begin
            n_cmp++; if ({ack_log[0], ack_log[1], ack_log[2]} !== {32'h200, 32'h204, 32'h208}) begin
                n_err++; $display("FAIL b2b_order got=%h,%h,%h exp=200,204,208", ack_log[0], ack_log[1], ack_log[2]);
            end
        end
    endtask

    task automatic test_reset_mid_req;
        ack_log.delete();
        MACK = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_0300, 32'h3333_3333);
        tick;
        drive(1'b1, 2'b10, 32'h0000_0304, 32'h4444_4444);
        tick;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        n_cmp++; if (MREQ !== 1'b1) begin n_err++; $display("FAIL rmid_mreq_pre got=%b exp=1", MREQ); end
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL rmid_mreq got=%b exp=0", MREQ); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rmid_empty got=%b exp=1", EMPTY); end
        n_cmp++; if (FULL !== 1'b0) begin n_err++; $display("FAIL rmid_full got=%b exp=0", FULL); end
        tick;
        RST_N = 1'b1;
        MACK  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (MREQ !== 1'b0) begin n_err++; $display("FAIL rmid_stale%0d got=%b exp=0", i, MREQ); end
        end
        MACK = 1'b0;
        n_cmp++; if (ack_log.size() !== 0) begin n_err++; $display("FAIL rmid_acks got=%0d exp=0", ack_log.size()); end
    endtask

    initial begin
        test_reset;
        test_sw;
        test_sb;
        test_sh;
        test_misaligned;
        test_back_to_back;
        test_reset_mid_req;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Memory-write counterpart to the data-read register on the multicycle CPU's memory read path.
- Accepts store requests (sw/sh/sb) from the datapath in the MEM cycle and byte-aligns the write data.
- Generates per-byte enables, queues stores in a small FIFO, and drains them to data memory over a request/acknowledge handshake.
- Tells the control unit to stall only when the queue cannot take a new store.

Parameters:
- DEPTH, 2, number of queued stores (power of two, 2..8).
- AW, 32, address width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- WE  input  1  store request from control, valid for one cycle.
- SIZE  input  2  store size: 00 byte, 01 half, 10 word, 11 reserved (treated as misaligned).
- ADDR  input  AW  byte address from ALUOut.
- WD  input  32  store data from the B register, value right-justified.
- STALL  output  1  combinational: WE & FULL.
- ERR  output  1  registered one-cycle pulse for a misaligned or reserved-size store.
- FULL  output  1  registered, count == DEPTH.
- EMPTY  output  1  registered, count == 0.
- MREQ  output  1  memory write request.
- MADDR  output  AW  word address: head entry address with bits [1:0] = 00.
- MWD  output  32  lane-aligned write data.
- MBE  output  4  byte enables; bit i covers MWD[8i+7:8i].
- MACK  input  1  memory accepts the current write on this edge.

Behaviour:
- Reset (RST_N low, asynchronous):
  - count = 0, read/write pointers = 0, FSM in IDLE.
  - MREQ = 0, MADDR = 0, MWD = 0, MBE = 0, ERR = 0, FULL = 0, EMPTY = 1.
  - Stored entries are discarded.
  - Reset during REQ aborts the transfer; MREQ drops immediately.
- Alignment, computed when a store is accepted (a = ADDR[1:0]):
  - Word: a must be 00. MBE = 1111, MWD = WD.
  - Half: a[0] must be 0. MBE = 0011 << a. MWD = {2{WD[15:0]}}.
  - Byte: any a. MBE = 0001 << a. MWD = {4{WD[7:0]}}.
  - Misaligned or SIZE = 11: the store is not enqueued and ERR pulses on the next cycle.
- Enqueue:
  - Occurs on the edge where WE = 1, FULL = 0 and the store is aligned.
  - The entry holds {word address, MWD, MBE}.
  - WE while FULL: the store is not taken, STALL = 1, and control must hold WE/ADDR/WD/SIZE until STALL drops.
  - FULL with MACK in the same cycle: STALL still asserts. The slot frees on that edge and the store is taken on the next cycle.
- FSM:
  - IDLE: MREQ = 0. Go to REQ on the edge after count becomes nonzero.
  - REQ: MREQ = 1, and MADDR/MWD/MBE present the head entry, held stable until MACK.
  - On MACK, the head is popped on that edge.
    - If count after the pop is > 0, stay in REQ and present the next entry on the following cycle with no bubble.
    - Otherwise return to IDLE.
  - MACK in IDLE is ignored.
- Simultaneous enqueue and pop in the same edge (not full): count is unchanged and both pointers advance.
- Latency: a store accepted on edge N appears on MREQ after edge N+1, or behind older queued entries.
- Ordering: strict FIFO. Writes to memory occur in issue order.
- Pointers wrap modulo DEPTH.
- Outputs MADDR/MWD/MBE reflect the head entry (from registers) and hold their last value in IDLE.

Decomposition:
- Shared package holds:
  - SIZE encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - FSM state encodings: IDLE = 1'b0, REQ = 1'b1.
- One sub-module: store_align. It is combinational: SIZE, ADDR[1:0], WD -> MWD, MBE, misaligned.
- FIFO storage and the FSM stay in store_write_buffer.

Test Plan:
- Reset, then sw ADDR = 0x00000104, WD = 0xDEADBEEF, with MACK tied high one cycle after MREQ:
  - MREQ rises one cycle after acceptance.
  - MADDR = 0x00000104, MWD = 0xDEADBEEF, MBE = 1111.
  - Returns to IDLE, EMPTY = 1.
- sb ADDR = 0x00000013, WD = 0x000000A5:
  - MBE = 1000, MWD = 0xA5A5A5A5, MADDR = 0x00000010.
- sh ADDR = 0x00000022, WD = 0x00001234:
  - MBE = 1100, MWD = 0x12341234.
- sh ADDR = 0x00000021:
  - ERR pulses one cycle, nothing enqueued, EMPTY stays 1, MREQ stays 0.
- MACK held low, then three sw issued back-to-back (DEPTH = 2):
  - First two are accepted, FULL = 1.
  - Third sees STALL = 1 until MACK is pulsed.
  - All three writes appear in order with no idle cycle between acknowledged entries.
- RST_N driven low mid-REQ with 2 entries queued:
  - MREQ = 0 immediately, EMPTY = 1.
  - After release, no stale write is issued.
